gf180mcu_osu_dffn_bist: RTL and testbench

- Built-in self-test controller for silicon characterisation of the 9T negative-edge flop cells.
- Upstream side: generates a PRBS7 stream on D_OUT that drives the flop-under-test D pin.
- Downstream side: consumes the flop's Q/QN after a fixed latency and compares them against the delayed expected stream.
- Reports a saturating error count and a pass flag.

---
 rtl/gf180mcu_osu_dffn_bist.sv | 101 ++++++++++
 tb/tb_gf180mcu_osu_dffn_bist.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_osu_dffn_bist.sv
// gf180mcu_osu_dffn_bist: PRBS7 BIST controller for characterising the 9T negative-edge flop cells.
// Ports:
//   clk_i      - single clock, all state updates on the rising edge
//   rst_i      - synchronous active-high reset, has priority over start_i
//   start_i    - begin a test; only honoured in IDLE or DONE
//   len_i      - number of bits to launch, captured when start_i is accepted
//   d_out_o    - PRBS7 stimulus to the flop-under-test D pin, 0 outside RUN
//   q_in_i     - flop-under-test Q
//   qn_in_i    - flop-under-test QN
//   busy_o     - high in RUN and DRAIN
//   done_o     - high in DONE
//   err_cnt_o  - saturating mismatch count
//   pass_o     - done_o with a zero error count
module gf180mcu_osu_dffn_bist #(
    parameter int         LEN_W = 8,
    parameter int         ERR_W = 8,
    parameter int         LAT   = 2,
    parameter logic [6:0] SEED  = 7'h7F
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             d_out_o,
    input  logic             q_in_i,
    input  logic             qn_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             pass_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // An all-zero seed would lock the LFSR, so it is replaced.
    localparam logic [6:0]       SEED_EFF   = (SEED == 7'd0) ? 7'h7F : SEED;
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;
    localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(LAT - 1);

    state_e           state_q;
    logic [6:0]       lfsr_q;
    logic [6:0]       lfsr_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_d;
    // Each stage holds {valid, expected bit}; the last stage is the compare tap.
    logic [1:0]       dly_q [LAT];
    logic             accept;
    logic             last_bit;
    logic             drain_end;
    logic             mismatch;

    assign accept    = start_i && (state_q == IDLE || state_q == DONE);
    assign last_bit  = cnt_q == len_q - 1'b1;
    assign drain_end = cnt_q == DRAIN_LAST;
    assign lfsr_d    = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    // A broken QN path (not the inverse of Q) counts as a failure even when Q is right.
    assign mismatch  = dly_q[LAT-1][1] && (q_in_i != dly_q[LAT-1][0] || qn_in_i == q_in_i);
    assign err_d     = (mismatch && err_q != ERR_MAX) ? err_q + 1'b1 : err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            for (int k = 0; k < LAT; k++) dly_q[k] <= '0;
        end else begin
            dly_q[0] <= {state_q == RUN, lfsr_q[6]};
            for (int k = 1; k < LAT; k++) dly_q[k] <= dly_q[k-1];
            if (accept) begin
                lfsr_q  <= SEED_EFF;
                len_q   <= len_i;
                cnt_q   <= '0;
                err_q   <= '0;
                state_q <= (len_i != '0) ? RUN : DRAIN;
            end else begin
                err_q <= err_d;
                case (state_q)
                    RUN: begin
                        lfsr_q  <= lfsr_d;
                        cnt_q   <= last_bit ? '0 : cnt_q + 1'b1;
                        state_q <= last_bit ? DRAIN : RUN;
                    end
                    DRAIN: begin
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= drain_end ? DONE : DRAIN;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign d_out_o   = (state_q == RUN) & lfsr_q[6];
    assign busy_o    = state_q == RUN || state_q == DRAIN;
    assign done_o    = state_q == DONE;
    assign err_cnt_o = err_q;
    assign pass_o    = done_o && err_q == '0;
endmodule

// File: tb/tb_gf180mcu_osu_dffn_bist.sv
// tb_gf180mcu_osu_dffn_bist: table-driven and randomized bench for the flop BIST controller.
module tb_gf180mcu_osu_dffn_bist;
    localparam int LAT = 2;
    localparam int IDEAL = 0, STUCK = 1, QNEQ = 2, RAND = 3;

    typedef struct {
        int len;
        int mode;
        int exp_err;
        int poke;
    } vec_t;

    logic       clk = 0, rst = 1, start = 0;
    logic [7:0] len_in = 0;
    logic       q_in = 0, qn_in = 1, d_out, busy, done, pass;
    logic [7:0] err;
    logic       q_s = 0, qn_s = 1, d_out_s, busy_s, done_s, pass_s;
    logic [3:0] err_s;
    logic       q_z = 0, qn_z = 1, d_out_z, busy_z, done_z, pass_z;
    logic [7:0] err_z;

    int   vectors = 0, miscompares = 0;
    int   exp_err = 0, exp_s = 0, pend = 0, pend_s = 0;
    bit   pa [300];
    bit   pz [300];
    logic hq [$];
    logic hs [$];
    vec_t tbl [10];

    always #5 clk = ~clk;

    gf180mcu_osu_dffn_bist #(.LEN_W(8), .ERR_W(8), .LAT(LAT), .SEED(7'h55)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len_in), .d_out_o(d_out),
        .q_in_i(q_in), .qn_in_i(qn_in), .busy_o(busy), .done_o(done), .err_cnt_o(err), .pass_o(pass));

    gf180mcu_osu_dffn_bist #(.LEN_W(8), .ERR_W(4), .LAT(LAT), .SEED(7'h55)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len_in), .d_out_o(d_out_s),
        .q_in_i(q_s), .qn_in_i(qn_s), .busy_o(busy_s), .done_o(done_s), .err_cnt_o(err_s), .pass_o(pass_s));

    gf180mcu_osu_dffn_bist #(.LEN_W(8), .ERR_W(8), .LAT(LAT), .SEED(7'h00)) dut_z (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len_in), .d_out_o(d_out_z),
        .q_in_i(q_z), .qn_in_i(qn_z), .busy_o(busy_z), .done_o(done_z), .err_cnt_o(err_z), .pass_o(pass_z));

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // PRBS7 x^7+x^6+1 as a bit sequence: seed MSB-first, then o[n+7] = o[n] ^ o[n+1].
    task automatic gen_prbs(input logic [6:0] seed, output bit p [300]);
        for (int i = 0; i < 7; i++) p[i] = seed[6-i];
        for (int i = 7; i < 300; i++) p[i] = p[i-7] ^ p[i-6];
    endtask

    // One clock: settle the pending compare into the expected counts, check the
    // outputs for cycle k after the accept edge, then drive the flop model.
    task automatic tick(input int k, input int len, input int mode, input bit chk);
        logic       qi, qsi;
        logic [1:0] f;
        int         slot;
        bit         lau;
        @(posedge clk);
        #1;
        exp_err = (exp_err + pend > 255) ? 255 : exp_err + pend;
        exp_s   = (exp_s + pend_s > 15) ? 15 : exp_s + pend_s;
        pend    = 0;
        pend_s  = 0;
        if (chk) begin
            check($sformatf("d_out k=%0d", k), d_out, k < len ? int'(pa[k]) : 0);
            check($sformatf("d_out_seed0 k=%0d", k), d_out_z, k < len ? int'(pz[k]) : 0);
            check($sformatf("busy k=%0d", k), busy, k < len + LAT);
            check($sformatf("busy_w4 k=%0d", k), busy_s, k < len + LAT);
            check($sformatf("busy_seed0 k=%0d", k), busy_z, k < len + LAT);
            check($sformatf("done k=%0d", k), done, k >= len + LAT);
            check($sformatf("done_seed0 k=%0d", k), done_z, k >= len + LAT);
            check($sformatf("err_live k=%0d", k), err, exp_err);
            check($sformatf("err_w4_live k=%0d", k), err_s, exp_s);
        end
        hq.push_back(d_out);
        qi = hq.pop_front();
        hs.push_back(d_out_s);
        qsi = hs.pop_front();
        slot = k - LAT;
        lau = chk && slot >= 0 && slot < len;
        f = 2'($urandom);
        case (mode)
            STUCK: begin q_in = 1'b0; qn_in = 1'b1; end
            QNEQ:  begin q_in = qi; qn_in = qi; end
            RAND:  begin q_in = qi ^ f[0]; qn_in = f[1] ? qi ^ f[0] : ~(qi ^ f[0]); end
            default: begin q_in = qi; qn_in = ~qi; end
        endcase
        q_s  = lau ? ~qsi : 1'($urandom);
        qn_s = ~q_s;
        if (lau) begin
            pend   = (q_in != pa[slot] || qn_in == q_in) ? 1 : 0;
            pend_s = (q_s != pa[slot] || qn_s == q_s) ? 1 : 0;
        end
    endtask

    task automatic run_vec(input int len, input int mode, input int texp, input int poke);
        exp_err = 0;
        exp_s   = 0;
        len_in  = 8'(len);
        start   = 1;
        tick(0, len, mode, 1);
        start = 0;
        for (int k = 1; k <= len + LAT + 1; k++) begin
            if (k == poke) begin
                start  = 1;
                len_in = 8'd3;
            end
            tick(k, len, mode, 1);
            start = 0;
        end
        check($sformatf("done len=%0d", len), done, 1);
        check($sformatf("done_w4 len=%0d", len), done_s, 1);
        check($sformatf("pass len=%0d", len), pass, exp_err == 0);
        check($sformatf("pass_w4 len=%0d", len), pass_s, exp_s == 0);
        check($sformatf("err_w4_sat len=%0d", len), err_s, len < 15 ? len : 15);
        if (texp >= 0) check($sformatf("err_table len=%0d mode=%0d", len, mode), err, texp);
    endtask

    initial begin
        int len, poke;
        gen_prbs(7'h55, pa);
        gen_prbs(7'h7F, pz);
        for (int i = 0; i < LAT; i++) begin
            hq.push_back(1'b0);
            hs.push_back(1'b0);
        end
        tbl[0] = '{100, IDEAL, 0, -1};
        tbl[1] = '{7, STUCK, 4, -1};
        tbl[2] = '{20, QNEQ, 20, -1};
        tbl[3] = '{0, IDEAL, 0, -1};
        tbl[4] = '{1, STUCK, 1, -1};
        tbl[5] = '{20, IDEAL, 0, 5};
        tbl[6] = '{7, STUCK, 4, -1};
        tbl[7] = '{255, IDEAL, 0, -1};
        tbl[8] = '{50, RAND, -1, 30};
        tbl[9] = '{2, QNEQ, 2, -1};

        for (int i = 0; i < 3; i++) tick(0, 0, IDEAL, 0);
        rst = 0;
        check("reset d_out", d_out, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        check("reset pass", pass, 0);
        check("reset pass_seed0", pass_z, 0);
        check("reset err_seed0", err_z, 0);
        tick(0, 0, IDEAL, 0);
        check("idle done", done, 0);

        for (int i = 0; i < 10; i++) run_vec(tbl[i].len, tbl[i].mode, tbl[i].exp_err, tbl[i].poke);

        exp_err = 0;
        exp_s   = 0;
        len_in  = 8'd100;
        start   = 1;
        tick(0, 100, STUCK, 1);
        start = 0;
        for (int k = 1; k <= 30; k++) tick(k, 100, STUCK, 1);
        check("err_before_rst_nonzero", exp_err > 0, 1);
        rst = 1;
        tick(31, 100, STUCK, 0);
        rst = 0;
        exp_err = 0;
        pend    = 0;
        check("midrst d_out", d_out, 0);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst err", err, 0);
        check("midrst pass", pass, 0);
        for (int i = 0; i < LAT + 2; i++) begin
            tick(0, 0, STUCK, 0);
            check($sformatf("post_rst err i=%0d", i), err, 0);
            check($sformatf("post_rst busy i=%0d", i), busy, 0);
            check($sformatf("post_rst done i=%0d", i), done, 0);
        end

        for (int r = 0; r < 6; r++) begin
            len  = $urandom_range(0, 150);
            poke = len > 2 ? $urandom_range(1, len) : -1;
            run_vec(len, RAND, -1, poke);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
